// File: rtl/ds_stream_sender_if.sv
// rtl/ds_stream_sender_if.sv - NAP tx stream bundle driven by ds_stream_sender
interface ds_stream_sender_if #(
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 4
);
   logic                  tx_valid;
   logic                  tx_ready;
   logic [DATA_WIDTH-1:0] tx_data;
   logic [ADDR_WIDTH-1:0] tx_addr;
   logic                  tx_sop;
   logic                  tx_eop;

   modport master (
      output tx_valid,
      output tx_data,
      output tx_addr,
      output tx_sop,
      output tx_eop,
      input  tx_ready
   );

   modport slave (
      input  tx_valid,
      input  tx_data,
      input  tx_addr,
      input  tx_sop,
      input  tx_eop,
      output tx_ready
   );
endinterface

// File: rtl/ds_stream_sender.sv
// rtl/ds_stream_sender.sv - periodic multi-beat NoC packet sender with round-robin destinations
module ds_stream_sender #(
   parameter int                       DATA_WIDTH    = 256,
   parameter int                       ADDR_WIDTH    = 4,
   parameter int                       NUM_DEST      = 4,
   parameter int                       PAYLOAD_WIDTH = 8,
   parameter logic [PAYLOAD_WIDTH-1:0] LFSR_TAPS     = 8'hB8,
   parameter int                       MAX_BEATS     = 8,
   parameter int                       CNT_WIDTH     = 16,
   localparam int                      BEATS_W       = $clog2(MAX_BEATS + 1)
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           enable,
   input  logic [31:0]                    period,
   input  logic [BEATS_W-1:0]             beats,
   input  logic [1:0]                     mode,
   input  logic [PAYLOAD_WIDTH-1:0]       seed,
   input  logic [NUM_DEST-1:0]            dest_mask,
   input  logic [NUM_DEST*ADDR_WIDTH-1:0] dest_cols,
   ds_stream_sender_if.master             tx,
   output logic                           busy,
   output logic [CNT_WIDTH-1:0]           pkt_count,
   output logic [CNT_WIDTH-1:0]           overrun_count,
   output logic [CNT_WIDTH-1:0]           stall_count
);
   localparam int PTR_W = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND} state_t;

   state_t                   state_q, state_d;
   logic [31:0]              timer_q;
   logic [31:0]              period_m1;
   logic                     tick;
   logic                     run_ok;
   logic                     accept;
   logic                     last_beat;
   logic                     eop_accept;
   logic                     start;
   logic [PTR_W-1:0]         ptr_q;
   logic [PTR_W-1:0]         sel_slot;
   logic [PTR_W-1:0]         ptr_next;
   logic                     found;
   int                       slot_j;
   logic [BEATS_W-1:0]       beats_cl;
   logic [BEATS_W-1:0]       lat_beats_q;
   logic [BEATS_W-1:0]       beat_idx_q;
   logic [1:0]               lat_mode_q;
   logic [PAYLOAD_WIDTH-1:0] payload_q;
   logic                     valid_q;
   logic                     sop_q;
   logic [ADDR_WIDTH-1:0]    addr_q;

   function automatic logic [PAYLOAD_WIDTH-1:0] advance(input logic [1:0] m,
                                                        input logic [PAYLOAD_WIDTH-1:0] p);
      logic [PAYLOAD_WIDTH-1:0] r;
      r = p;
      case (m)
         2'b00: r = p + PAYLOAD_WIDTH'(1);
         2'b01: r = (p == '0) ? PAYLOAD_WIDTH'(1) : ((p << 1) | (p >> (PAYLOAD_WIDTH - 1)));
         2'b10: begin
            if (p == '0)   r = PAYLOAD_WIDTH'(1);
            else if (p[0]) r = (p >> 1) ^ LFSR_TAPS;
            else           r = p >> 1;
         end
         default: r = p;
      endcase
      return r;
   endfunction

   assign period_m1  = (period == 32'd0) ? 32'd0 : period - 32'd1;
   assign tick       = (state_q != S_IDLE) && (timer_q == period_m1);
   assign run_ok     = enable && (|dest_mask);
   assign accept     = valid_q && tx.tx_ready;
   assign last_beat  = (beat_idx_q == lat_beats_q - BEATS_W'(1));
   assign eop_accept = (state_q == S_SEND) && accept && last_beat;
   assign start      = (state_q == S_WAIT) && run_ok && tick;

   always_comb begin
      beats_cl = beats;
      if (beats == '0)                 beats_cl = BEATS_W'(1);
      else if (int'(beats) > MAX_BEATS) beats_cl = BEATS_W'(MAX_BEATS);
   end

   // First enabled slot at or after the pointer, searching cyclically.
   always_comb begin
      sel_slot = '0;
      found    = 1'b0;
      slot_j   = 0;
      for (int k = 0; k < NUM_DEST; k++) begin
         slot_j = int'(ptr_q) + k;
         if (slot_j >= NUM_DEST) slot_j = slot_j - NUM_DEST;
         if (!found && dest_mask[slot_j]) begin
            found    = 1'b1;
            sel_slot = PTR_W'(slot_j);
         end
      end
   end

   assign ptr_next = (int'(sel_slot) == NUM_DEST - 1) ? '0 : sel_slot + PTR_W'(1);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (run_ok) state_d = S_WAIT;
         S_WAIT: begin
            if (!run_ok)   state_d = S_IDLE;
            else if (tick) state_d = S_SEND;
         end
         S_SEND: if (eop_accept) state_d = run_ok ? S_WAIT : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         timer_q       <= '0;
         ptr_q         <= '0;
         payload_q     <= '0;
         lat_beats_q   <= '0;
         lat_mode_q    <= '0;
         beat_idx_q    <= '0;
         valid_q       <= 1'b0;
         sop_q         <= 1'b0;
         addr_q        <= '0;
         pkt_count     <= '0;
         overrun_count <= '0;
         stall_count   <= '0;
      end else begin
         if (state_q == S_IDLE || tick) timer_q <= '0;
         else                           timer_q <= timer_q + 32'd1;

         if (state_q == S_IDLE)
            payload_q <= seed;
         else if (state_q == S_SEND && accept)
            payload_q <= advance(lat_mode_q, payload_q);

         if (start) begin
            lat_beats_q <= beats_cl;
            lat_mode_q  <= mode;
            addr_q      <= dest_cols[int'(sel_slot)*ADDR_WIDTH +: ADDR_WIDTH];
            ptr_q       <= ptr_next;
            beat_idx_q  <= '0;
            valid_q     <= 1'b1;
            sop_q       <= 1'b1;
         end else if (state_q == S_SEND && accept) begin
            sop_q <= 1'b0;
            if (last_beat) valid_q    <= 1'b0;
            else           beat_idx_q <= beat_idx_q + BEATS_W'(1);
         end

         pkt_count <= pkt_count + CNT_WIDTH'(eop_accept);
         // A tick that lands while a packet is still in flight is lost, not queued.
         if (state_q == S_SEND && tick && !(&overrun_count))
            overrun_count <= overrun_count + CNT_WIDTH'(1);
         if (valid_q && !tx.tx_ready && !(&stall_count))
            stall_count <= stall_count + CNT_WIDTH'(1);
      end
   end

   assign tx.tx_valid = valid_q;
   assign tx.tx_sop   = sop_q;
   assign tx.tx_eop   = valid_q && last_beat;
   assign tx.tx_addr  = addr_q;
   assign tx.tx_data  = valid_q ? DATA_WIDTH'({8'(beat_idx_q), payload_q}) : '0;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_ds_stream_sender.sv
// tb/tb_ds_stream_sender.sv - directed self-checking bench for ds_stream_sender
module tb_ds_stream_sender;
   localparam int DW = 256;
   localparam int AW = 4;
   localparam int ND = 4;
   localparam int PW = 8;
   localparam int MB = 8;
   localparam int CW = 16;
   localparam int BW = 4;

   logic           clk = 1'b0;
   logic           resetn = 1'b0;
   logic           enable = 1'b0;
   logic [31:0]    period = 32'd10;
   logic [BW-1:0]  beats = 4'd1;
   logic [1:0]     mode = 2'b00;
   logic [PW-1:0]  seed = 8'h05;
   logic [ND-1:0]  dest_mask = '0;
   logic [ND*AW-1:0] dest_cols = '0;
   logic           busy;
   logic [CW-1:0]  pkt_count;
   logic [CW-1:0]  overrun_count;
   logic [CW-1:0]  stall_count;

   ds_stream_sender_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) tx_if ();

   ds_stream_sender #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_DEST(ND), .PAYLOAD_WIDTH(PW),
      .LFSR_TAPS(8'hB8), .MAX_BEATS(MB), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .resetn(resetn), .enable(enable), .period(period), .beats(beats),
      .mode(mode), .seed(seed), .dest_mask(dest_mask), .dest_cols(dest_cols),
      .tx(tx_if), .busy(busy), .pkt_count(pkt_count),
      .overrun_count(overrun_count), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic wait_valid(input string tag, input int budget, output int waited);
      waited = 0;
      while (!tx_if.tx_valid && waited < budget) begin
         step();
         waited++;
      end
      check({tag, " valid"}, tx_if.tx_valid, 1);
   endtask

   task automatic check_beat(input string tag, input int idx, input logic [7:0] pl,
                             input logic sop, input logic eop);
      check({tag, " valid"}, tx_if.tx_valid, 1);
      check({tag, " idx"}, tx_if.tx_data[15:8], idx);
      check({tag, " payload"}, tx_if.tx_data[7:0], pl);
      check({tag, " sop"}, tx_if.tx_sop, sop);
      check({tag, " eop"}, tx_if.tx_eop, eop);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      enable = 1'b0;
      tx_if.tx_ready = 1'b1;
      step();
      step();
      check("rst valid", tx_if.tx_valid, 0);
      check("rst busy", busy, 0);
      check("rst data", tx_if.tx_data[63:0], 0);
      check("rst addr", tx_if.tx_addr, 0);
      check("rst sop/eop", {tx_if.tx_sop, tx_if.tx_eop}, 0);
      check("rst counters", {pkt_count, overrun_count, stall_count}, 0);
      resetn = 1'b1;
      step();
   endtask

   initial begin
      int w;
      int n;
      logic eop_seen;
      logic stable;
      logic [DW-1:0] snap_data;
      logic [AW-1:0] snap_addr;
      logic [7:0] lfsr_exp [4];
      lfsr_exp[0] = 8'h01; lfsr_exp[1] = 8'hB8; lfsr_exp[2] = 8'h5C; lfsr_exp[3] = 8'h2E;
      tx_if.tx_ready = 1'b1;

      // 1: single-beat packets to one column, incrementing payload
      do_reset();
      period = 32'd10; beats = 4'd1; mode = 2'b00; seed = 8'h05;
      dest_mask = 4'b0001; dest_cols = {4'd0, 4'd0, 4'd0, 4'd2};
      enable = 1'b1;
      wait_valid("t1 first", 30, w);
      for (int p = 0; p < 3; p++) begin
         check("t1 addr", tx_if.tx_addr, 2);
         check_beat("t1 beat", 0, 8'h05 + 8'(p), 1'b1, 1'b1);
         check("t1 data hi", tx_if.tx_data[DW-1:16] == '0, 1);
         step();
         if (p < 2) begin
            check("t1 valid drop", tx_if.tx_valid, 0);
            wait_valid("t1 next", 20, w);
            check("t1 gap", w, 9);
         end
      end
      check("t1 pkt_count", pkt_count, 3);
      check("t1 overrun", overrun_count, 0);

      // 2: round-robin over mask 1011, beats=0 clamps to one beat
      do_reset();
      period = 32'd4; beats = 4'd0;
      dest_mask = 4'b1011; dest_cols = {4'd4, 4'd3, 4'd2, 4'd1};
      enable = 1'b1;
      for (int p = 0; p < 6; p++) begin
         wait_valid("t2 pkt", 20, w);
         check("t2 addr", tx_if.tx_addr, (p % 3 == 0) ? 1 : (p % 3 == 1) ? 2 : 4);
         check("t2 eop clamp", tx_if.tx_eop, 1);
         step();
      end
      dest_mask = 4'b0000;
      step();
      check("t2 idle busy", busy, 0);
      check("t2 idle valid", tx_if.tx_valid, 0);

      // 2b: beats above MAX_BEATS clamp to MAX_BEATS
      dest_mask = 4'b0001; beats = 4'hF;
      wait_valid("t2b pkt", 20, w);
      n = 0;
      eop_seen = 1'b0;
      for (int i = 0; i < 20 && !eop_seen; i++) begin
         n++;
         eop_seen = tx_if.tx_eop;
         step();
      end
      check("t2b clamp beats", n, MB);

      // 3: backpressure for 30 cycles from first SOP
      do_reset();
      period = 32'd10; beats = 4'd4; mode = 2'b00; seed = 8'h10;
      dest_mask = 4'b0001; dest_cols = {4'd0, 4'd0, 4'd0, 4'd2};
      tx_if.tx_ready = 1'b0;
      enable = 1'b1;
      wait_valid("t3 first", 30, w);
      snap_data = tx_if.tx_data;
      snap_addr = tx_if.tx_addr;
      stable = 1'b1;
      for (int i = 0; i < 30; i++) begin
         step();
         if (!tx_if.tx_valid || tx_if.tx_data !== snap_data || tx_if.tx_addr !== snap_addr ||
             tx_if.tx_sop !== 1'b1 || tx_if.tx_eop !== 1'b0)
            stable = 1'b0;
      end
      check("t3 held stable", stable, 1);
      check("t3 stall_count", stall_count, 30);
      check("t3 overrun_count", overrun_count, 3);
      tx_if.tx_ready = 1'b1;
      for (int b = 0; b < 4; b++) begin
         check_beat("t3 beat", b, 8'h10 + 8'(b), b == 0, b == 3);
         step();
      end
      check("t3 pkt_count", pkt_count, 1);
      check("t3 stall after", stall_count, 30);
      check("t3 valid after", tx_if.tx_valid, 0);

      // 4: LFSR then walking-one payload sequences
      do_reset();
      period = 32'd5; beats = 4'd4; mode = 2'b10; seed = 8'h01;
      dest_mask = 4'b0001;
      enable = 1'b1;
      wait_valid("t4 lfsr", 20, w);
      for (int b = 0; b < 4; b++) begin
         check("t4 lfsr payload", tx_if.tx_data[7:0], lfsr_exp[b]);
         step();
      end
      enable = 1'b0; seed = 8'h80; mode = 2'b01; beats = 4'd3;
      step();
      enable = 1'b1;
      wait_valid("t4 walk80", 20, w);
      for (int b = 0; b < 3; b++) begin
         check("t4 walk80 payload", tx_if.tx_data[7:0], (b == 0) ? 8'h80 : (b == 1) ? 8'h01 : 8'h02);
         step();
      end
      enable = 1'b0; seed = 8'h00;
      step();
      enable = 1'b1;
      wait_valid("t4 walk00", 20, w);
      for (int b = 0; b < 3; b++) begin
         check("t4 walk00 payload", tx_if.tx_data[7:0], (b == 0) ? 8'h00 : (b == 1) ? 8'h01 : 8'h02);
         step();
      end

      // 5: enable dropped mid-packet, then reset mid-packet
      do_reset();
      period = 32'd10; beats = 4'd4; mode = 2'b00; seed = 8'h20;
      dest_mask = 4'b0001;
      enable = 1'b1;
      wait_valid("t5 first", 30, w);
      step();
      step();
      enable = 1'b0;
      check_beat("t5 beat2", 2, 8'h22, 1'b0, 1'b0);
      step();
      check_beat("t5 beat3", 3, 8'h23, 1'b0, 1'b1);
      step();
      check("t5 idle busy", busy, 0);
      check("t5 pkt_count", pkt_count, 1);
      enable = 1'b1;
      tx_if.tx_ready = 1'b0;
      wait_valid("t5 second", 30, w);
      step();
      #2;
      resetn = 1'b0;
      #1;
      check("t5 async valid", tx_if.tx_valid, 0);
      check("t5 async counters", {pkt_count, stall_count}, 0);
      check("t5 async busy", busy, 0);
      step();
      resetn = 1'b1;
      tx_if.tx_ready = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
